spi_slave_regs: RTL and testbench

SPI slave block at the peripheral end of the SPI link driven by the AHB SPI master. It is the receiving counterpart to that master's transmitter.
- Clocked directly by the SPI serial clock; only advances while the master clocks.
- Deserialises MOSI bytes into a small register bank, e.g. display digit values.
- Serialises read-back data onto MISO.
- Gives the consuming logic a toggle event per committed write; that logic synchronises the toggle into its own clock domain.

---
 rtl/spi_slave_pkg.sv | 30 +++
 rtl/spi_slave_regs_if.sv | 25 ++
 rtl/spi_byte_shifter.sv | 72 +++++++
 rtl/spi_slave_regs.sv | 167 ++++++++++++++++
 tb/tb_spi_slave_regs.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_pkg
// Shared definitions for the SPI slave register block: byte geometry, command
// byte layout, FSM state encoding and the layout of the status byte that is
// shifted out on MISO while the command byte is being received.
// -----------------------------------------------------------------------------
package spi_slave_pkg;

  localparam int BYTE_W     = 8;
  localparam int CMD_RD_BIT = 7;   // command bit 7: 1 = read-only frame

  // Status byte layout: {err, 3'b0, wr_toggle, 3'b0}
  localparam int STAT_ERR_BIT = 7;
  localparam int STAT_TOG_BIT = 3;

  typedef enum logic [1:0] {
    ST_ADDR,
    ST_DATA,
    ST_DROP
  } state_t;

  function automatic logic [BYTE_W-1:0] status_byte(input logic err, input logic tog);
    logic [BYTE_W-1:0] s;
    s               = '0;
    s[STAT_ERR_BIT] = err;
    s[STAT_TOG_BIT] = tog;
    return s;
  endfunction

endpackage

// File: rtl/spi_slave_regs_if.sv
// -----------------------------------------------------------------------------
// spi_slave_regs_if
// The three SPI link wires between the AHB SPI master and this slave.
//   spi_ss_n_i  : slave select, active low (master -> slave)
//   spi_mosi_i  : serial data, MSB first    (master -> slave)
//   spi_miso_o  : serial data, MSB first    (slave  -> master)
// The _i/_o suffixes are from the slave's point of view.
// -----------------------------------------------------------------------------
interface spi_slave_regs_if;
  logic spi_ss_n_i;
  logic spi_mosi_i;
  logic spi_miso_o;

  modport master (
    output spi_ss_n_i,
    output spi_mosi_i,
    input  spi_miso_o
  );

  modport slave (
    input  spi_ss_n_i,
    input  spi_mosi_i,
    output spi_miso_o
  );
endinterface

// File: rtl/spi_byte_shifter.sv
// -----------------------------------------------------------------------------
// spi_byte_shifter
// Bit-level SPI engine, mode 0, rising edge only.
//   SPI_clk_x   : SPI serial clock
//   HRESETn     : async active-low reset (clears the MISO output flop)
//   clr_i       : async frame clear (reset or slave deselected); clears the
//                 bit counter and both shift registers
//   mosi_i      : serial input
//   load_i      : on this edge present load_byte_i on MISO (MSB now)
//   load_byte_i : byte to serialise
//   rx_byte_o   : byte formed by the 7 stored bits plus the live MOSI bit;
//                 meaningful when byte_done_o is high
//   byte_done_o : high during the bit time whose rising edge completes a byte
//   bit_cnt_o   : bits already received in the current byte
//   miso_o      : registered serial output
// -----------------------------------------------------------------------------
module spi_byte_shifter
  import spi_slave_pkg::*;
(
  input  logic              SPI_clk_x,
  input  logic              HRESETn,
  input  logic              clr_i,
  input  logic              mosi_i,
  input  logic              load_i,
  input  logic [BYTE_W-1:0] load_byte_i,
  output logic [BYTE_W-1:0] rx_byte_o,
  output logic              byte_done_o,
  output logic [2:0]        bit_cnt_o,
  output logic              miso_o
);

  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-2:0] in_sr_q, in_sr_d;     // the 8th bit is taken live from MOSI
  logic [BYTE_W-1:0] out_sr_q, out_sr_d;
  logic              miso_q, miso_d;

  assign rx_byte_o   = {in_sr_q, mosi_i};
  assign byte_done_o = (bit_cnt_q == 3'd7);
  assign bit_cnt_o   = bit_cnt_q;
  assign miso_o      = miso_q;

  always_comb begin
    bit_cnt_d = bit_cnt_q + 3'd1;          // wraps 7 -> 0 at byte end
    in_sr_d   = rx_byte_o[BYTE_W-2:0];
    if (load_i) begin
      miso_d   = load_byte_i[BYTE_W-1];
      out_sr_d = {load_byte_i[BYTE_W-2:0], 1'b0};
    end else begin
      miso_d   = out_sr_q[BYTE_W-1];
      out_sr_d = {out_sr_q[BYTE_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge SPI_clk_x or posedge clr_i) begin
    if (clr_i) begin
      bit_cnt_q <= '0;
      in_sr_q   <= '0;
      out_sr_q  <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      in_sr_q   <= in_sr_d;
      out_sr_q  <= out_sr_d;
    end
  end

  // MISO holds its last bit across deselect; only reset returns it to 0.
  always_ff @(posedge SPI_clk_x or negedge HRESETn) begin
    if (!HRESETn) miso_q <= 1'b0;
    else          miso_q <= miso_d;
  end

endmodule

// File: rtl/spi_slave_regs.sv
// -----------------------------------------------------------------------------
// spi_slave_regs
// SPI slave register bank clocked by the SPI serial clock. Frame: ss_n low,
// command byte {RD, index[6:0]}, then data bytes written (RD=0) to successive
// registers with index wrap. Read-back data streams out on MISO.
//   SPI_clk_x   : SPI serial clock (mode 0, rising edge)
//   HRESETn     : async active-low reset
//   spi         : SPI link (ss_n, mosi, miso), slave modport
//   regs_o      : flattened bank, reg k at [8k+7:8k]
//   wr_toggle_o : inverts once per committed data-byte write
//   last_idx_o  : index of the most recent committed write
//   err_o       : sticky, a frame addressed an index >= NUM_REGS
// -----------------------------------------------------------------------------
module spi_slave_regs
  import spi_slave_pkg::*;
#(
  parameter  int NUM_REGS = 8,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                     SPI_clk_x,
  input  logic                     HRESETn,
  spi_slave_regs_if.slave          spi,
  output logic [NUM_REGS*8-1:0]    regs_o,
  output logic                     wr_toggle_o,
  output logic [IDX_W-1:0]         last_idx_o,
  output logic                     err_o
);

  // Frame-scoped state is cleared whenever the slave is deselected.
  logic frame_clr;
  assign frame_clr = ~HRESETn | spi.spi_ss_n_i;

  logic [BYTE_W-1:0] rx_byte;
  logic              byte_done;
  logic [2:0]        bit_cnt;
  logic              load;
  logic [BYTE_W-1:0] load_byte;
  logic              miso;

  spi_byte_shifter u_shifter (
    .SPI_clk_x   (SPI_clk_x),
    .HRESETn     (HRESETn),
    .clr_i       (frame_clr),
    .mosi_i      (spi.spi_mosi_i),
    .load_i      (load),
    .load_byte_i (load_byte),
    .rx_byte_o   (rx_byte),
    .byte_done_o (byte_done),
    .bit_cnt_o   (bit_cnt),
    .miso_o      (miso)
  );

  assign spi.spi_miso_o = miso;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               rd_q, rd_d;
  logic               wr_en;
  logic               err_set;
  logic [IDX_W-1:0]   rd_idx;
  logic [6:0]         cmd_idx;
  logic               tog_q;
  logic [IDX_W-1:0]   last_idx_q;
  logic               err_q;
  logic [NUM_REGS*8-1:0] bank_flat;

  assign cmd_idx = rx_byte[6:0];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rd_d      = rd_q;
    wr_en     = 1'b0;
    err_set   = 1'b0;
    load      = 1'b0;
    load_byte = '0;
    rd_idx    = idx_q;
    case (state_q)
      ST_ADDR: begin
        // First edge of a frame: load the status byte. Its MSB is driven after
        // edge 1, so the master sees status bits [7:1] at edges 2..8; bit 0 is
        // always zero and is the one that does not fit.
        if (bit_cnt == 3'd0) begin
          load      = 1'b1;
          load_byte = status_byte(err_q, tog_q);
        end
        if (byte_done) begin
          load = 1'b1;
          rd_d = rx_byte[CMD_RD_BIT];
          if (int'(cmd_idx) >= NUM_REGS) begin
            state_d   = ST_DROP;
            err_set   = 1'b1;
            load_byte = '0;
          end else begin
            state_d   = ST_DATA;
            idx_d     = cmd_idx[IDX_W-1:0];
            rd_idx    = cmd_idx[IDX_W-1:0];
            load_byte = bank_flat[rd_idx*BYTE_W +: BYTE_W];
          end
        end
      end
      ST_DATA: begin
        if (byte_done) begin
          wr_en     = ~rd_q;
          idx_d     = idx_q + 1'b1;    // natural wrap, NUM_REGS is a power of two
          rd_idx    = idx_q + 1'b1;
          load      = 1'b1;
          // reg[idx+1] is never the register written on this edge
          load_byte = bank_flat[rd_idx*BYTE_W +: BYTE_W];
        end
      end
      ST_DROP: begin
        if (byte_done) begin
          load      = 1'b1;
          load_byte = '0;
        end
      end
      default: state_d = ST_ADDR;
    endcase
  end

  always_ff @(posedge SPI_clk_x or posedge frame_clr) begin
    if (frame_clr) begin
      state_q <= ST_ADDR;
      idx_q   <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bank
      logic [BYTE_W-1:0] reg_q;
      always_ff @(posedge SPI_clk_x or negedge HRESETn) begin
        if (!HRESETn)
          reg_q <= '0;
        else if (wr_en && (idx_q == IDX_W'(gi)))
          reg_q <= rx_byte;
      end
      assign bank_flat[gi*BYTE_W +: BYTE_W] = reg_q;
    end
  endgenerate

  always_ff @(posedge SPI_clk_x or negedge HRESETn) begin
    if (!HRESETn) begin
      tog_q      <= 1'b0;
      last_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (wr_en) begin
        tog_q      <= ~tog_q;
        last_idx_q <= idx_q;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign regs_o      = bank_flat;
  assign wr_toggle_o = tog_q;
  assign last_idx_o  = last_idx_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
`timescale 1ns/1ps
module tb_spi_slave_regs;
  import spi_slave_pkg::*;

  localparam int NUM_REGS = 8;
  localparam int IDX_W    = 3;

  logic SPI_clk_x = 1'b0;
  logic HRESETn   = 1'b0;
  logic clk_run   = 1'b0;

  spi_slave_regs_if spi ();

  logic [NUM_REGS*8-1:0] regs_o;
  logic                  wr_toggle_o;
  logic [IDX_W-1:0]      last_idx_o;
  logic                  err_o;

  spi_slave_regs #(.NUM_REGS(NUM_REGS)) dut (
    .SPI_clk_x   (SPI_clk_x),
    .HRESETn     (HRESETn),
    .spi         (spi),
    .regs_o      (regs_o),
    .wr_toggle_o (wr_toggle_o),
    .last_idx_o  (last_idx_o),
    .err_o       (err_o)
  );

  // Clock runs only while enabled; always parks low.
  always begin
    #5;
    if (clk_run || SPI_clk_x) SPI_clk_x = ~SPI_clk_x;
  end

  // ---------------- reference model and scoreboard ----------------
  logic [7:0]       m_regs [NUM_REGS];
  logic             m_tog;
  logic [IDX_W-1:0] m_last;
  logic             m_err;

  typedef struct packed {
    logic [7:0] val;
    logic [7:0] mask;
  } rx_exp_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [7:0]       data;
    logic [15:0]      edge_n;
  } cmt_t;

  rx_exp_t    rx_exp_q[$];
  logic [7:0] rx_obs_q[$];
  cmt_t       cmt_q[$];
  logic [7:0] fq[$];

  int   errors = 0;
  int   checks = 0;
  int   edge_cnt = 0;
  logic mon_resync = 1'b1;
  logic prev_tog = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] m_flat();
    logic [63:0] f;
    for (int k = 0; k < NUM_REGS; k++) f[k*8 +: 8] = m_regs[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_REGS; k++) m_regs[k] = 8'h00;
    m_tog  = 1'b0;
    m_last = '0;
    m_err  = 1'b0;
  endtask

  // Monitor: consumes MISO bytes and write-commit events independently of
  // the stimulus, comparing against expectations queued at issue time.
  always @(negedge SPI_clk_x) begin
    rx_exp_t e;
    cmt_t    c;
    logic [7:0] o;
    while (rx_obs_q.size() != 0) begin
      o = rx_obs_q.pop_front();
      if (rx_exp_q.size() == 0) begin
        check("miso_unexpected_byte", 64'(o), 64'hx);
      end else begin
        e = rx_exp_q.pop_front();
        check("miso_byte", 64'(o & e.mask), 64'(e.val & e.mask));
      end
    end
    if (mon_resync) begin
      prev_tog   = wr_toggle_o;
      mon_resync = 1'b0;
    end else if (wr_toggle_o !== prev_tog) begin
      prev_tog = wr_toggle_o;
      if (cmt_q.size() == 0) begin
        check("unexpected_toggle", 64'(wr_toggle_o), 64'(~wr_toggle_o));
      end else begin
        c = cmt_q.pop_front();
        check("commit_data", 64'(regs_o[c.idx*8 +: 8]), 64'(c.data));
        check("commit_last_idx", 64'(last_idx_o), 64'(c.idx));
        check("commit_edge", 64'(edge_cnt), 64'(c.edge_n));
        $display("commit reg%0d <= %02h at edge %0d", c.idx, c.data, edge_cnt);
      end
    end
  end

  // ---------------- driver ----------------
  // Starts and ends at a falling edge; MISO is sampled just before each
  // rising edge, which is when the master latches it.
  task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      rx[i] = spi.spi_miso_o;
      spi.spi_mosi_i = tx[i];
      @(posedge SPI_clk_x);
      edge_cnt++;
      @(negedge SPI_clk_x);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_bank"}, regs_o, m_flat());
    check({tag, "_toggle"}, 64'(wr_toggle_o), 64'(m_tog));
    check({tag, "_last_idx"}, 64'(last_idx_o), 64'(m_last));
    check({tag, "_err"}, 64'(err_o), 64'(m_err));
  endtask

  // Runs the frame held in fq, optionally followed by a partial byte.
  task automatic run_frame(input int abort_bits, input logic [7:0] abort_byte);
    logic [7:0] rx;
    logic [7:0] st;
    logic       rd;
    int         idx;
    logic       bad;
    rd  = fq[0][7];
    idx = int'(fq[0][6:0]);
    bad = (idx >= NUM_REGS);
    // Status bits [7:1] reach the master at edges 2..8 of the command byte.
    st = {m_err, 3'b000, m_tog, 3'b000};
    rx_exp_q.push_back('{val: st >> 1, mask: 8'h7F});
    if (bad) m_err = 1'b1;
    for (int j = 1; j < fq.size(); j++) begin
      if (bad) begin
        rx_exp_q.push_back('{val: 8'h00, mask: 8'hFF});
      end else begin
        rx_exp_q.push_back('{val: m_regs[idx], mask: 8'hFF});
        if (!rd) begin
          m_regs[idx] = fq[j];
          m_tog       = ~m_tog;
          m_last      = IDX_W'(idx);
          cmt_q.push_back('{idx: IDX_W'(idx), data: fq[j], edge_n: 16'(8 * (j + 1))});
        end
        idx = (idx + 1) % NUM_REGS;
      end
    end
    $display("frame cmd=%02h bytes=%0d abort_bits=%0d", fq[0], fq.size(), abort_bits);
    @(negedge SPI_clk_x);
    edge_cnt = 0;
    spi.spi_ss_n_i = 1'b0;
    foreach (fq[j]) begin
      xfer_bits(fq[j], 8, rx);
      rx_obs_q.push_back(rx);
    end
    if (abort_bits > 0) xfer_bits(abort_byte, abort_bits, rx);
    spi.spi_ss_n_i = 1'b1;
    repeat (2) @(negedge SPI_clk_x);
    check_state("frame");
  endtask

  initial begin
    logic [7:0] rx;
    int nb;
    spi.spi_ss_n_i = 1'b1;
    spi.spi_mosi_i = 1'b0;
    model_reset();

    // Reset with the clock idle
    HRESETn = 1'b0;
    #20;
    check("rst_regs", regs_o, 64'h0);
    check("rst_err", 64'(err_o), 64'h0);
    check("rst_toggle", 64'(wr_toggle_o), 64'h0);
    check("rst_miso", 64'(spi.spi_miso_o), 64'h0);
    check("rst_last_idx", 64'(last_idx_o), 64'h0);
    HRESETn = 1'b1;
    #3;
    clk_run = 1'b1;
    mon_resync = 1'b1;
    repeat (2) @(negedge SPI_clk_x);

    // Single write; commit expected at edge 16
    fq = '{8'h03, 8'h08};             run_frame(0, 8'h00);
    // Burst with index wrap 6,7,0
    fq = '{8'h06, 8'hAA, 8'hBB, 8'hCC}; run_frame(0, 8'h00);
    // Out-of-range index, then err stays sticky across a valid frame
    fq = '{8'h13, 8'h55};             run_frame(0, 8'h00);
    fq = '{8'h04, 8'h11};             run_frame(0, 8'h00);
    // Read-back
    fq = '{8'h02, 8'h3C};             run_frame(0, 8'h00);
    fq = '{8'h82, 8'h00};             run_frame(0, 8'h00);
    // Partial byte discarded, then a clean write
    fq = '{8'h01};                    run_frame(4, 8'hF0);
    fq = '{8'h01, 8'h5A};             run_frame(0, 8'h00);

    // Reset mid-byte: bank and sticky state clear, next frame decodes cleanly
    $display("reset mid-frame");
    @(negedge SPI_clk_x);
    edge_cnt = 0;
    spi.spi_ss_n_i = 1'b0;
    rx_exp_q.push_back('{val: 8'({m_err, 3'b000, m_tog, 3'b000} >> 1), mask: 8'h7F});
    xfer_bits(8'h05, 8, rx);
    rx_obs_q.push_back(rx);
    xfer_bits(8'hA5, 3, rx);
    mon_resync = 1'b1;
    HRESETn = 1'b0;
    model_reset();
    @(negedge SPI_clk_x);
    HRESETn = 1'b1;
    spi.spi_ss_n_i = 1'b1;
    mon_resync = 1'b1;
    repeat (2) @(negedge SPI_clk_x);
    check_state("midrst");
    fq = '{8'h01, 8'h77};             run_frame(0, 8'h00);

    // Randomised frames
    for (int t = 0; t < 40; t++) begin
      fq = {};
      fq.push_back({1'($urandom_range(0, 3) == 0), 7'($urandom_range(0, 9))});
      nb = $urandom_range(0, 5);
      for (int j = 0; j < nb; j++) fq.push_back(8'($urandom));
      if ($urandom_range(0, 5) == 0)
        run_frame($urandom_range(1, 7), 8'($urandom));
      else
        run_frame(0, 8'h00);
    end

    // Final reset with clock idle
    clk_run = 1'b0;
    #30;
    mon_resync = 1'b1;
    HRESETn = 1'b0;
    model_reset();
    #10;
    check("final_rst_regs", regs_o, 64'h0);
    check("final_rst_err", 64'(err_o), 64'h0);
    check("final_rst_toggle", 64'(wr_toggle_o), 64'h0);
    check("final_rst_miso", 64'(spi.spi_miso_o), 64'h0);
    HRESETn = 1'b1;
    clk_run = 1'b1;
    repeat (3) @(negedge SPI_clk_x);

    check("rx_queue_drained", 64'(rx_exp_q.size()), 64'h0);
    check("commit_queue_drained", 64'(cmt_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
